uart_text_tx: RTL and testbench
===============================

# uart_text_tx

UART transmit side of the text console. It accepts bytes from on-chip sources through a single-cycle write strobe, such as keyboard echo or a buffer dump from the VGA text memory. It buffers them in a small FIFO and serializes them as 8N1 frames on `tx`. It is the counterpart of the receive path that feeds the text display. It can optionally expand carriage return (0x0D) into CR+LF so that terminals mirror the on-screen line-break behaviour.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s. `DIV = CLK_FREQ / BAUD`, truncated. `DIV` must be ≥ 2.
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of two and ≥ 2.
- `CRLF_EXPAND`, 1: when 1, each transmitted 0x0D is followed by an inserted 0x0A.

Ports:
- `clk`, input, 1: system clock. All logic runs on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `wr_en`, input, 1: write strobe. Sampled on each rising edge, one byte per high cycle.
- `wr_data`, input, 8: byte to send. Sampled when `wr_en` is high.
- `full`, output, 1: FIFO holds `FIFO_DEPTH` entries.
- `overflow`, output, 1: sticky flag. Set when a write is dropped. Cleared only by reset.
- `busy`, output, 1: high while a frame is on the line, an LF insert is pending, or the FIFO is non-empty.
- `tx`, output, 1: serial line. Registered, idle high.

## Operation
- Reset values: `tx`=1, `busy`=0, `full`=0, `overflow`=0. FIFO is empty, FSM is in IDLE, baud counter=0, bit index=0.
- Write handling:
  - `wr_en` with `full`=0 pushes `wr_data`.
  - `wr_en` with `full`=1 drops the byte and sets `overflow`.
  - `full` is evaluated before any same-cycle pop. A write while full is dropped even if a pop occurs on the same edge.
- FSM states:
  - **IDLE**: `tx`=1. If the FIFO is non-empty, pop into the shift register, drive `tx`=0, go to START.
  - **START**: hold `tx`=0 for `DIV` cycles, then go to DATA with bit index 0.
  - **DATA**: drive shift bit `[idx]`, LSB first, for `DIV` cycles each. After idx 7, go to STOP.
  - **STOP**: hold `tx`=1 for `DIV` cycles. Then:
    - If an LF insert is pending, load 0x0A and go to START. The FIFO is not popped.
    - Else if the FIFO is non-empty, pop and go to START with no idle gap.
    - Else go to IDLE.
- LF insert: `CRLF_EXPAND`=1 and a popped byte equal to 0x0D sets the pending flag. It is cleared when 0x0A is loaded. An inserted 0x0A never triggers further expansion. A 0x0A written by the user is sent unmodified.
- Baud counter: counts 0..`DIV`-1 and is cleared on every state change. Width is `$clog2(DIV)`.
- FIFO pointers: `$clog2(FIFO_DEPTH)`+1 bits, wrap-around. Full when the MSBs differ and the lower bits are equal. Empty when the pointers are equal.
- Reset asserted mid-frame: `tx` returns to 1 immediately, without waiting for a clock. The partial frame is abandoned, the FIFO is cleared, and any pending LF is discarded.

## Timing
- Write-to-line latency: with the FIFO empty and the FSM in IDLE, a write sampled at edge k makes `tx` fall at edge k+2.
- Frame length: exactly 10×`DIV` cycles. For an expanded CR, the CR+LF pair takes 20×`DIV` cycles.
- Back-to-back frames: the next start bit begins on the edge that ends the stop bit.
- `full` and `busy` are registered, and updated on the edge of the push or pop. Each reflects that edge's push/pop.
- `busy` falls on the same edge that the FSM enters IDLE with the FIFO empty.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP).
  - Constants `ASCII_CR`=8'h0D and `ASCII_LF`=8'h0A.
  - A `baud_div(clk_freq, baud)` function.
  - The receive path imports the same package.
- Sub-module `sync_fifo`: parameterized width and depth, with push/pop, full/empty, asynchronous reset.
- The FSM, baud counter and LF-insert logic live in the top module.

## Test plan
Use `CLK_FREQ`=1600 and `BAUD`=100 (`DIV`=16) in all scenarios.
1. Write 0x41 once → `tx` falls 2 edges later, then carries 0,1,0,0,0,0,0,1,0,1 for 16 cycles each. `busy` drops after 160 cycles.
2. Write 0x55, 0xAA on consecutive cycles → two frames with no idle gap: 320 cycles of `busy`, and the stop bit of frame 1 is followed directly by the start bit of frame 2.
3. Write 0x0D with `CRLF_EXPAND`=1 → frames 0x0D then 0x0A. Write 0x0A → a single 0x0A frame. With `CRLF_EXPAND`=0, 0x0D gives a single frame.
4. Hold `FIFO_DEPTH`+2 writes during the first frame → `full` asserts after 16 accepted entries (17 with the one already popped). The extra bytes are dropped and `overflow`=1 until reset. Exactly 17 frames are sent.
5. Write while full on the same edge as an internal pop → the byte is dropped and `overflow` is set.
6. Assert reset in DATA at bit 3 → `tx`=1 immediately, `busy`=0, FIFO empty. A write after release sends a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the text-console UART transmit and receive paths.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Clock cycles per bit, truncated.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers one bit wider than the address.
// The caller must not push when full or pop when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);

endmodule

// File: rtl/uart_text_tx.sv
// Text-console UART transmitter: write FIFO, 8N1 serializer, optional CR -> CR+LF expansion.
// The line register follows the FSM by one cycle, giving a two-edge write-to-start latency.
module uart_text_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CRLF_EXPAND = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       tx
);
    localparam int unsigned    DIV      = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned    CW       = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          lf_q, lf_d;
    logic          tx_q, tx_d;
    logic          ovf_q;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_rdata;
    logic       bit_done, head_is_cr;

    // Full is judged on the pre-edge occupancy, so a same-edge pop never rescues a write.
    assign fifo_push = wr_en && !fifo_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (wr_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bit_done   = (cnt_q == CNT_LAST);
    assign head_is_cr = (CRLF_EXPAND != 0) && (fifo_rdata == ASCII_CR);

    // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_done ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        lf_d     = lf_q;
        fifo_pop = 1'b0;
        tx_d     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    lf_d     = head_is_cr;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[idx_q];
                if (bit_done) begin
                    if (idx_q == 3'd7) state_d = ST_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    // A pending LF takes priority over the FIFO and never expands again.
                    if (lf_q) begin
                        shift_d = ASCII_LF;
                        lf_d    = 1'b0;
                        state_d = ST_START;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        lf_d     = head_is_cr;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            lf_q    <= 1'b0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            lf_q    <= lf_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_q | (wr_en & fifo_full);
        end
    end

    assign tx       = tx_q;
    assign full     = fifo_full;
    assign overflow = ovf_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_text_tx.sv
// Bench for uart_text_tx: one instance with CR expansion, one without, both decoded by line monitors.
module tb_uart_text_tx;
    localparam int DIV   = 16;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en0, wr_en1;
    logic [7:0] wr_data0, wr_data1;
    logic       full0, full1, overflow0, overflow1, busy0, busy1, tx0, tx1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] rxq0[$], rxq1[$], exp0[$], exp1[$];
    int         rxt0[$], rxt1[$];

    typedef struct {
        int         ch;
        logic [7:0] din;
        int         nfr;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_text_tx #(.CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(16), .CRLF_EXPAND(1)) u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_data(wr_data0),
        .full(full0), .overflow(overflow0), .busy(busy0), .tx(tx0));

    uart_text_tx #(.CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(16), .CRLF_EXPAND(0)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_data(wr_data1),
        .full(full1), .overflow(overflow1), .busy(busy1), .tx(tx1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic line(input int ch);
        return (ch == 0) ? tx0 : tx1;
    endfunction

    function automatic logic busy_of(input int ch);
        return (ch == 0) ? busy0 : busy1;
    endfunction

    // Decodes whole frames, insisting that every bit is held for exactly DIV cycles.
    task automatic monitor(input int ch);
        logic [9:0] bits;
        logic       flat, aborted;
        int         t0;
        forever begin
            @(negedge clk);
            if (!reset && line(ch) === 1'b0) begin
                t0 = cyc; flat = 1'b1; aborted = 1'b0; bits = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < DIV; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (reset) aborted = 1'b1;
                        if (!aborted) begin
                            if (c == 0) bits[b] = line(ch);
                            else if (line(ch) !== bits[b]) flat = 1'b0;
                        end
                    end
                end
                if (!aborted) begin
                    check($sformatf("ch%0d bit width", ch), {31'd0, flat}, 32'd1);
                    check($sformatf("ch%0d stop bit", ch), {31'd0, bits[9]}, 32'd1);
                    if (ch == 0) begin rxq0.push_back(bits[8:1]); rxt0.push_back(t0); end
                    else         begin rxq1.push_back(bits[8:1]); rxt1.push_back(t0); end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic clear_all();
        rxq0.delete(); rxq1.delete(); rxt0.delete(); rxt1.delete();
        exp0.delete(); exp1.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en0 = 1'b0; wr_en1 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_all();
    endtask

    // Returns on the negedge after the sampling edge, so cyc then equals that edge's index.
    task automatic wr(input int ch, input logic [7:0] d);
        if (ch == 0) begin wr_en0 = 1'b1; wr_data0 = d; end
        else         begin wr_en1 = 1'b1; wr_data1 = d; end
        @(negedge clk);
        wr_en0 = 1'b0; wr_en1 = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_idle(input int ch, input int budget, input string name);
        int n = 0;
        while (busy_of(ch) !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle"}, {31'd0, busy_of(ch)}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic cmp_stream(input int ch, input string name);
        if (ch == 0) begin
            check({name, " count"}, rxq0.size(), exp0.size());
            for (int i = 0; i < exp0.size() && i < rxq0.size(); i++)
                check($sformatf("%s byte%0d", name, i), {24'd0, rxq0[i]}, {24'd0, exp0[i]});
        end else begin
            check({name, " count"}, rxq1.size(), exp1.size());
            for (int i = 0; i < exp1.size() && i < rxq1.size(); i++)
                check($sformatf("%s byte%0d", name, i), {24'd0, rxq1[i]}, {24'd0, exp1[i]});
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e0;
        logic [7:0] d;

        vecs[0] = '{ch: 0, din: 8'h0D, nfr: 2, b0: 8'h0D, b1: 8'h0A};
        vecs[1] = '{ch: 0, din: 8'h0A, nfr: 1, b0: 8'h0A, b1: 8'h00};
        vecs[2] = '{ch: 1, din: 8'h0D, nfr: 1, b0: 8'h0D, b1: 8'h00};
        vecs[3] = '{ch: 1, din: 8'h0A, nfr: 1, b0: 8'h0A, b1: 8'h00};
        vecs[4] = '{ch: 0, din: 8'h7E, nfr: 1, b0: 8'h7E, b1: 8'h00};

        reset = 1'b1; wr_en0 = 1'b0; wr_en1 = 1'b0; wr_data0 = '0; wr_data1 = '0;
        do_reset();
        check("reset tx", {31'd0, tx0}, 32'd1);
        check("reset busy", {31'd0, busy0}, 32'd0);
        check("reset full", {31'd0, full0}, 32'd0);
        check("reset overflow", {31'd0, overflow0}, 32'd0);

        // Single 0x41 frame: latency, busy window, content.
        wr(0, 8'h41); e = cyc;
        wait_cyc(e + FRAME);     check("t1 busy high", {31'd0, busy0}, 32'd1);
        wait_cyc(e + FRAME + 1); check("t1 busy low", {31'd0, busy0}, 32'd0);
        wait_idle(0, 400, "t1");
        check("t1 frames", rxq0.size(), 1);
        if (rxq0.size() > 0) begin
            check("t1 byte", {24'd0, rxq0[0]}, 32'h41);
            check("t1 latency", rxt0[0], e + 2);
        end

        // Back-to-back frames with no idle gap.
        clear_all();
        wr(0, 8'h55); e = cyc; wr(0, 8'hAA);
        wait_cyc(e + 2 * FRAME);     check("t2 busy high", {31'd0, busy0}, 32'd1);
        wait_cyc(e + 2 * FRAME + 1); check("t2 busy low", {31'd0, busy0}, 32'd0);
        wait_idle(0, 400, "t2");
        exp0.push_back(8'h55); exp0.push_back(8'hAA);
        cmp_stream(0, "t2");
        if (rxt0.size() == 2) check("t2 gap", rxt0[1] - rxt0[0], FRAME);

        // CR expansion table.
        for (int i = 0; i < 5; i++) begin
            clear_all();
            wr(vecs[i].ch, vecs[i].din); e = cyc;
            wait_idle(vecs[i].ch, 1000, $sformatf("t3 v%0d", i));
            if (vecs[i].ch == 0) begin
                check($sformatf("t3 v%0d frames", i), rxq0.size(), vecs[i].nfr);
                if (rxq0.size() > 0) begin
                    check($sformatf("t3 v%0d b0", i), {24'd0, rxq0[0]}, {24'd0, vecs[i].b0});
                    check($sformatf("t3 v%0d latency", i), rxt0[0], e + 2);
                end
                if (vecs[i].nfr == 2 && rxq0.size() == 2) begin
                    check($sformatf("t3 v%0d b1", i), {24'd0, rxq0[1]}, {24'd0, vecs[i].b1});
                    check($sformatf("t3 v%0d gap", i), rxt0[1] - rxt0[0], FRAME);
                end
            end else begin
                check($sformatf("t3 v%0d frames", i), rxq1.size(), vecs[i].nfr);
                if (rxq1.size() > 0)
                    check($sformatf("t3 v%0d b0", i), {24'd0, rxq1[0]}, {24'd0, vecs[i].b0});
            end
        end

        // Random bytes with random gaps, never enough to fill the FIFO.
        clear_all();
        for (int i = 0; i < 14; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom);
            wr_en0 = 1'b1; wr_data0 = d; wr_en1 = 1'b1; wr_data1 = d;
            @(negedge clk);
            wr_en0 = 1'b0; wr_en1 = 1'b0;
            exp0.push_back(d);
            if (d == 8'h0D) exp0.push_back(8'h0A);
            exp1.push_back(d);
            repeat ($urandom_range(0, 250)) @(negedge clk);
        end
        wait_idle(0, 6000, "rnd ch0");
        wait_idle(1, 6000, "rnd ch1");
        cmp_stream(0, "rnd ch0");
        cmp_stream(1, "rnd ch1");
        check("rnd overflow0", {31'd0, overflow0}, 32'd0);
        check("rnd overflow1", {31'd0, overflow1}, 32'd0);

        // FIFO_DEPTH+2 writes in a row: 17 accepted, the last dropped.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            wr_en0 = 1'b1; wr_data0 = 8'(8'h30 + i);
            @(negedge clk);
            if (i == 15) check("t4 not full", {31'd0, full0}, 32'd0);
            if (i == 16) begin
                check("t4 full", {31'd0, full0}, 32'd1);
                check("t4 no ovf yet", {31'd0, overflow0}, 32'd0);
            end
            if (i == 17) check("t4 ovf", {31'd0, overflow0}, 32'd1);
        end
        wr_en0 = 1'b0;
        for (int i = 0; i < 17; i++) exp0.push_back(8'(8'h30 + i));
        wait_idle(0, 17 * FRAME + 200, "t4");
        cmp_stream(0, "t4");
        check("t4 ovf sticky", {31'd0, overflow0}, 32'd1);

        // Write while full on the same edge as a pop.
        do_reset();
        e0 = cyc + 1;
        for (int i = 0; i < 17; i++) begin
            wr_en0 = 1'b1; wr_data0 = 8'(8'h60 + i);
            @(negedge clk);
        end
        wr_en0 = 1'b0;
        check("t5 full", {31'd0, full0}, 32'd1);
        wait_cyc(e0 + FRAME);
        check("t5 pre ovf", {31'd0, overflow0}, 32'd0);
        check("t5 pre full", {31'd0, full0}, 32'd1);
        wr(0, 8'hEE);
        check("t5 ovf", {31'd0, overflow0}, 32'd1);
        check("t5 full after pop", {31'd0, full0}, 32'd0);
        for (int i = 0; i < 17; i++) exp0.push_back(8'(8'h60 + i));
        wait_idle(0, 17 * FRAME + 200, "t5");
        cmp_stream(0, "t5");

        // Asynchronous reset during data bit 3.
        do_reset();
        wr(0, 8'hA5); e = cyc; wr(0, 8'h33);
        wait_cyc(e + 2 + 4 * DIV + 6);
        check("t6 bit3 low", {31'd0, tx0}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("t6 async tx", {31'd0, tx0}, 32'd1);
        check("t6 busy", {31'd0, busy0}, 32'd0);
        check("t6 full", {31'd0, full0}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("t6 stays idle", {31'd0, busy0}, 32'd0);
        clear_all();
        wr(0, 8'hC3); e = cyc;
        wait_idle(0, 400, "t6");
        exp0.push_back(8'hC3);
        cmp_stream(0, "t6");
        if (rxt0.size() > 0) check("t6 latency", rxt0[0], e + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
